// File: rtl/map_buffer_scheduler_pkg.sv
// Shared types and defaults for the double-buffered note-map scheduler.
package map_buffer_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_FULL = 2'd2,
        ST_SWAP = 2'd3
    } map_state_t;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_ADDR_W = 7;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        if (value == 16'hFFFF) begin
            return value;
        end else begin
            return value + 16'd1;
        end
    endfunction

endpackage

// File: rtl/map_sat_counter.sv
// 16-bit event counter that sticks at 16'hFFFF instead of wrapping.
module map_sat_counter
    import map_buffer_scheduler_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_inc,
    output logic [15:0] o_count
);

    logic [15:0] r_count;

    // Count register with synchronous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= 16'd0;
        end else if (i_inc) begin
            r_count <= sat_inc16(r_count);
        end else begin
            r_count <= r_count;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/map_buffer_scheduler.sv
// Ping-pong note-map buffer scheduler: loader fills the back RAM, renderer reads the front RAM.
// Optional swap/missed-tick statistics are built when MAP_SWAP_STATS_EN is defined.
module map_buffer_scheduler
    import map_buffer_scheduler_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              frame_tick,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              ram0_we,
    output logic [ADDR_W-1:0] ram0_addr,
    output logic [DATA_W-1:0] ram0_wdata,
    input  logic [DATA_W-1:0] ram0_rdata,
    output logic              ram1_we,
    output logic [ADDR_W-1:0] ram1_addr,
    output logic [DATA_W-1:0] ram1_wdata,
    input  logic [DATA_W-1:0] ram1_rdata,
`ifdef MAP_SWAP_STATS_EN
    output logic [15:0]       swap_count,
    output logic [15:0]       missed_tick_count,
`endif
    output logic              front_sel,
    output logic              swap_pulse
);

    localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};

    map_state_t        r_state;
    map_state_t        w_state_next;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic              r_front_sel;
    logic              r_swap_pulse;
    logic              r_rd_valid;
    logic              r_rd_sel;
    logic              w_wr_ready;
    logic              w_wr_accept;
    logic              w_swap_enter;
    logic              w_tick_missed;
    logic [DATA_W-1:0] w_back_wdata;
    logic [ADDR_W-1:0] w_front_addr;

    // Next-state and handshake decode.
    always_comb begin
        w_state_next  = r_state;
        w_wr_ready    = 1'b0;
        w_swap_enter  = 1'b0;
        w_tick_missed = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_wr_ready    = 1'b1;
                w_tick_missed = frame_tick;
                if (wr_valid) begin
                    w_state_next = (r_wr_ptr == PTR_LAST) ? ST_FULL : ST_FILL;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_FILL: begin
                w_wr_ready    = 1'b1;
                w_tick_missed = frame_tick;
                if (wr_valid && (r_wr_ptr == PTR_LAST)) begin
                    w_state_next = ST_FULL;
                end else begin
                    w_state_next = ST_FILL;
                end
            end
            ST_FULL: begin
                if (frame_tick) begin
                    w_state_next = ST_SWAP;
                    w_swap_enter = 1'b1;
                end else begin
                    w_state_next = ST_FULL;
                end
            end
            ST_SWAP: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // A write in the reset cycle is neither offered nor performed, so reset wins over it.
    assign wr_ready    = w_wr_ready & ~reset;
    assign w_wr_accept = wr_valid & w_wr_ready & ~reset;

    // State, write pointer, buffer select and read-response pipeline.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_wr_ptr     <= {ADDR_W{1'b0}};
            r_front_sel  <= 1'b0;
            r_swap_pulse <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_rd_sel     <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_wr_ptr     <= w_wr_accept ? (r_wr_ptr + PTR_ONE) : r_wr_ptr;
            r_front_sel  <= r_front_sel ^ w_swap_enter;
            r_swap_pulse <= w_swap_enter;
            r_rd_valid   <= rd_en;
            r_rd_sel     <= r_front_sel;
        end
    end

    // RAM port steering: the back RAM takes loader writes, the front RAM serves reads.
    always_comb begin
        w_back_wdata = w_wr_accept ? wr_data : {DATA_W{1'b0}};
        w_front_addr = rd_en ? rd_addr : {ADDR_W{1'b0}};
        if (r_front_sel) begin
            ram0_we    = w_wr_accept;
            ram0_addr  = r_wr_ptr;
            ram0_wdata = w_back_wdata;
            ram1_we    = 1'b0;
            ram1_addr  = w_front_addr;
            ram1_wdata = {DATA_W{1'b0}};
        end else begin
            ram0_we    = 1'b0;
            ram0_addr  = w_front_addr;
            ram0_wdata = {DATA_W{1'b0}};
            ram1_we    = w_wr_accept;
            ram1_addr  = r_wr_ptr;
            ram1_wdata = w_back_wdata;
        end
        if (!r_rd_valid) begin
            rd_data = {DATA_W{1'b0}};
        end else if (r_rd_sel) begin
            rd_data = ram1_rdata;
        end else begin
            rd_data = ram0_rdata;
        end
    end

    assign rd_valid   = r_rd_valid;
    assign front_sel  = r_front_sel;
    assign swap_pulse = r_swap_pulse;

`ifdef MAP_SWAP_STATS_EN
    map_sat_counter u_swap_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (w_swap_enter),
        .o_count (swap_count)
    );

    map_sat_counter u_missed_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (w_tick_missed),
        .o_count (missed_tick_count)
    );
`endif

endmodule

// File: tb/tb_map_buffer_scheduler.sv
// Directed bench for map_buffer_scheduler with behavioural 1-cycle-read RAMs.
module tb_map_buffer_scheduler;

    logic       clk = 1'b0;
    logic       reset, wr_valid, wr_ready, frame_tick, rd_en, rd_valid;
    logic [7:0] wr_data, rd_data;
    logic [6:0] rd_addr;
    logic       ram0_we, ram1_we, front_sel, swap_pulse;
    logic [6:0] ram0_addr, ram1_addr;
    logic [7:0] ram0_wdata, ram1_wdata, ram0_rdata, ram1_rdata;
`ifdef MAP_SWAP_STATS_EN
    logic [15:0] swap_count, missed_tick_count;
`endif
    logic [7:0] mem0 [0:127];
    logic [7:0] mem1 [0:127];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    map_buffer_scheduler dut (
        .clk(clk), .reset(reset),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .frame_tick(frame_tick),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .ram0_we(ram0_we), .ram0_addr(ram0_addr), .ram0_wdata(ram0_wdata), .ram0_rdata(ram0_rdata),
        .ram1_we(ram1_we), .ram1_addr(ram1_addr), .ram1_wdata(ram1_wdata), .ram1_rdata(ram1_rdata),
`ifdef MAP_SWAP_STATS_EN
        .swap_count(swap_count), .missed_tick_count(missed_tick_count),
`endif
        .front_sel(front_sel), .swap_pulse(swap_pulse)
    );

    // Read-first single-port RAM models.
    always @(posedge clk) begin
        if (ram0_we) mem0[ram0_addr] <= ram0_wdata;
        ram0_rdata <= mem0[ram0_addr];
        if (ram1_we) mem1[ram1_addr] <= ram1_wdata;
        ram1_rdata <= mem1[ram1_addr];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_writes(input int first, input int last, input logic [7:0] offset);
        for (int i = first; i <= last; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(i) + offset;
            step();
        end
        wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; wr_valid = 1'b0; wr_data = 8'h00; frame_tick = 1'b0; rd_en = 1'b0; rd_addr = 7'd0;
        repeat (3) step();
        reset = 1'b0;
        #1;
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready got %b exp 1", wr_ready); end
        checks++; if (front_sel !== 1'b0) begin errors++; $display("FAIL reset_front_sel got %b exp 0", front_sel); end
        checks++; if (swap_pulse !== 1'b0) begin errors++; $display("FAIL reset_swap_pulse got %b exp 0", swap_pulse); end
        checks++; if ({rd_valid, rd_data} !== 9'h000) begin errors++; $display("FAIL reset_rd got %b/%h exp 0/00", rd_valid, rd_data); end
        checks++; if ({ram0_we, ram1_we, ram0_wdata, ram1_wdata} !== 18'h0) begin errors++; $display("FAIL reset_we got %b%b exp 00", ram0_we, ram1_we); end
`ifdef MAP_SWAP_STATS_EN
        checks++; if ({swap_count, missed_tick_count} !== 32'h0) begin errors++; $display("FAIL reset_stats got %h/%h exp 0/0", swap_count, missed_tick_count); end
`endif
    endtask

    task automatic test_fill_swap();
        wr_valid = 1'b1; wr_data = 8'h00;
        #1;
        checks++; if ({ram1_we, ram1_addr, ram1_wdata} !== {1'b1, 7'd0, 8'h00}) begin errors++; $display("FAIL fill_first_write got %b/%h/%h exp 1/00/00", ram1_we, ram1_addr, ram1_wdata); end
        checks++; if ({ram0_we, ram0_wdata} !== 9'h000) begin errors++; $display("FAIL fill_front_quiet got %b/%h exp 0/00", ram0_we, ram0_wdata); end
        step();
        do_writes(1, 127, 8'h00);
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL full_wr_ready got %b exp 0", wr_ready); end
        checks++; if ({ram1_we, ram1_wdata} !== 9'h000) begin errors++; $display("FAIL full_no_we got %b/%h exp 0/00", ram1_we, ram1_wdata); end
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        #1;
        checks++; if ({swap_pulse, front_sel, wr_ready} !== 3'b110) begin errors++; $display("FAIL swap_cycle got pulse/front/ready=%b exp 110", {swap_pulse, front_sel, wr_ready}); end
        step();
        checks++; if ({swap_pulse, front_sel, wr_ready} !== 3'b011) begin errors++; $display("FAIL after_swap got pulse/front/ready=%b exp 011", {swap_pulse, front_sel, wr_ready}); end
    endtask

    task automatic test_read();
        rd_en = 1'b1; rd_addr = 7'd5;
        #1;
        checks++; if (ram1_addr !== 7'd5) begin errors++; $display("FAIL read_front_addr got %h exp 05", ram1_addr); end
        step();
        rd_addr = 7'd127;
        checks++; if ({rd_valid, rd_data} !== {1'b1, 8'h05}) begin errors++; $display("FAIL read_addr5 got %b/%h exp 1/05", rd_valid, rd_data); end
        step();
        rd_en = 1'b0; rd_addr = 7'd0;
        checks++; if ({rd_valid, rd_data} !== {1'b1, 8'h7F}) begin errors++; $display("FAIL read_addr127 got %b/%h exp 1/7f", rd_valid, rd_data); end
        step();
        checks++; if ({rd_valid, rd_data} !== 9'h000) begin errors++; $display("FAIL read_idle got %b/%h exp 0/00", rd_valid, rd_data); end
    endtask

    task automatic test_missed_tick();
        do_writes(0, 59, 8'h40);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
        checks++; if ({swap_pulse, front_sel, wr_ready} !== 3'b011) begin errors++; $display("FAIL missed_tick got pulse/front/ready=%b exp 011", {swap_pulse, front_sel, wr_ready}); end
`ifdef MAP_SWAP_STATS_EN
        checks++; if (missed_tick_count !== 16'd1) begin errors++; $display("FAIL missed_count got %0d exp 1", missed_tick_count); end
`endif
        wr_valid = 1'b1; wr_data = 8'h7C;
        #1;
        checks++; if ({ram0_we, ram0_addr, ram0_wdata} !== {1'b1, 7'd60, 8'h7C}) begin errors++; $display("FAIL fill_resume got %b/%0d/%h exp 1/60/7c", ram0_we, ram0_addr, ram0_wdata); end
        step();
        do_writes(61, 126, 8'h40);
        wr_valid = 1'b1; wr_data = 8'hBF; frame_tick = 1'b1;
        step();
        wr_valid = 1'b0; frame_tick = 1'b0;
        checks++; if ({swap_pulse, wr_ready, front_sel} !== 3'b001) begin errors++; $display("FAIL tick_on_last_write got pulse/ready/front=%b exp 001", {swap_pulse, wr_ready, front_sel}); end
        step();
        checks++; if ({swap_pulse, wr_ready} !== 2'b00) begin errors++; $display("FAIL tick_not_pending got pulse/ready=%b exp 00", {swap_pulse, wr_ready}); end
    endtask

    task automatic test_swap_race();
        rd_en = 1'b1; rd_addr = 7'd9; frame_tick = 1'b1;
        #1;
        checks++; if (ram1_addr !== 7'd9) begin errors++; $display("FAIL race_old_front_addr got %0d exp 9", ram1_addr); end
        step();
        frame_tick = 1'b0;
        #1;
        checks++; if ({swap_pulse, front_sel, ram0_addr} !== {2'b10, 7'd9}) begin errors++; $display("FAIL race_swap got pulse/front=%b%b addr0=%0d exp 10/9", swap_pulse, front_sel, ram0_addr); end
        checks++; if ({rd_valid, rd_data} !== {1'b1, 8'h09}) begin errors++; $display("FAIL race_old_data got %b/%h exp 1/09", rd_valid, rd_data); end
        step();
        rd_en = 1'b0; rd_addr = 7'd0;
        checks++; if ({rd_valid, rd_data} !== {1'b1, 8'h49}) begin errors++; $display("FAIL race_new_data got %b/%h exp 1/49", rd_valid, rd_data); end
        checks++; if ({swap_pulse, wr_ready} !== 2'b01) begin errors++; $display("FAIL race_idle got pulse/ready=%b exp 01", {swap_pulse, wr_ready}); end
`ifdef MAP_SWAP_STATS_EN
        checks++; if ({swap_count, missed_tick_count} !== {16'd2, 16'd2}) begin errors++; $display("FAIL race_stats got %0d/%0d exp 2/2", swap_count, missed_tick_count); end
`endif
    endtask

    task automatic test_reset_midfill();
        do_writes(0, 99, 8'h10);
        reset = 1'b1; wr_valid = 1'b1; wr_data = 8'h55;
        #1;
        checks++; if ({ram0_we, ram1_we} !== 2'b00) begin errors++; $display("FAIL reset_priority_we got %b%b exp 00", ram0_we, ram1_we); end
        step();
        reset = 1'b0; wr_data = 8'h80;
        #1;
        checks++; if ({front_sel, swap_pulse, wr_ready} !== 3'b001) begin errors++; $display("FAIL midreset_state got front/pulse/ready=%b exp 001", {front_sel, swap_pulse, wr_ready}); end
        checks++; if ({ram1_we, ram1_addr, ram0_we} !== {1'b1, 7'd0, 1'b0}) begin errors++; $display("FAIL midreset_ptr got we1=%b addr1=%0d we0=%b exp 1/0/0", ram1_we, ram1_addr, ram0_we); end
        do_writes(0, 127, 8'h80);
    endtask

    task automatic test_full_hold();
        wr_valid = 1'b1; wr_data = 8'h77;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if ({wr_ready, ram0_we, ram1_we} !== 3'b000) begin errors++; $display("FAIL full_hold_%0d got ready/we0/we1=%b exp 000", c, {wr_ready, ram0_we, ram1_we}); end
            step();
        end
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        checks++; if ({swap_pulse, front_sel, wr_ready, ram0_we, ram1_we} !== 5'b11000) begin errors++; $display("FAIL hold_swap got %b exp 11000", {swap_pulse, front_sel, wr_ready, ram0_we, ram1_we}); end
        step();
        rd_en = 1'b1; rd_addr = 7'd50;
        #1;
        checks++; if ({ram0_we, ram0_addr, ram0_wdata} !== {1'b1, 7'd0, 8'h77}) begin errors++; $display("FAIL next_write_ram0 got %b/%0d/%h exp 1/0/77", ram0_we, ram0_addr, ram0_wdata); end
        checks++; if ({ram1_we, ram1_wdata, ram1_addr} !== {1'b0, 8'h00, 7'd50}) begin errors++; $display("FAIL front_ram1_port got %b/%h/%0d exp 0/00/50", ram1_we, ram1_wdata, ram1_addr); end
`ifdef MAP_SWAP_STATS_EN
        checks++; if ({swap_count, missed_tick_count} !== {16'd1, 16'd0}) begin errors++; $display("FAIL hold_stats got %0d/%0d exp 1/0", swap_count, missed_tick_count); end
`endif
        step();
        wr_valid = 1'b0; rd_addr = 7'd100;
        checks++; if ({rd_valid, rd_data} !== {1'b1, 8'hB2}) begin errors++; $display("FAIL refill_addr50 got %b/%h exp 1/b2", rd_valid, rd_data); end
        step();
        rd_en = 1'b0; rd_addr = 7'd0;
        checks++; if ({rd_valid, rd_data} !== {1'b1, 8'hE4}) begin errors++; $display("FAIL refill_addr100 got %b/%h exp 1/e4", rd_valid, rd_data); end
        step();
    endtask

    initial begin
        for (int a = 0; a < 128; a++) begin
            mem0[a] = 8'h00;
            mem1[a] = 8'h00;
        end
        test_reset();
        test_fill_swap();
        test_read();
        test_missed_tick();
        test_swap_race();
        test_reset_midfill();
        test_full_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
